// File: rtl/uart_param_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_param_core
//  Description : Parametrised full-duplex UART. Baud divider, payload width,
//                parity mode and stop-bit count are set by parameters.
//                RX rejects start-bit glitches, flags framing/parity errors
//                and parks in BREAK while the line is held low. TX accepts
//                a byte per valid/ready handshake.
//  Ports       : sys_clk       - system clock (rising edge)
//                rst_n         - asynchronous active-low reset
//                rx / tx       - serial in (async) / serial out (idles high)
//                tx_data       - byte to send, bits [DATA_BITS-1:0] used
//                tx_valid      - transmit request
//                tx_ready      - transmitter idle, can accept a byte
//                rx_data       - received payload, upper bits zero
//                rx_valid      - one-cycle pulse, rx_data and flags updated
//                rx_frame_err  - first stop bit sampled low
//                rx_parity_err - parity mismatch (0 when parity disabled)
//                busy_flag     - TX or RX FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_param_core #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       busy_flag
);

    localparam int                 c_BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int                 c_CNT_W     = $clog2(c_BAUD_DIV) + 1;
    localparam logic [c_CNT_W-1:0] c_DIV_MAX   = c_CNT_W'(c_BAUD_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_MAX  = c_CNT_W'(c_BAUD_DIV / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [2:0]         c_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic               c_PAR_EN    = (PARITY != 0);
    localparam logic               c_PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // ------------------------------------------------------------------
    // rx synchroniser; idles high so reset does not look like a start bit
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t              r_tx_state, w_tx_state_nxt;
    logic [c_CNT_W-1:0]     r_tx_cnt,   w_tx_cnt_nxt;
    logic [2:0]             r_tx_bit,   w_tx_bit_nxt;
    logic [DATA_BITS-1:0]   r_tx_shift, w_tx_shift_nxt;
    logic                   r_tx_par,   w_tx_par_nxt;
    logic                   r_tx_line,  w_tx_line_nxt;
    logic                   w_tx_tick;
    logic [DATA_BITS-1:0]   w_tx_payload;
    logic                   w_unused_tx_data;

    assign w_tx_tick        = (r_tx_cnt == c_DIV_MAX);
    assign w_tx_payload     = tx_data[DATA_BITS-1:0];
    assign w_unused_tx_data = ^tx_data;

    // tx is registered, so the line changes on the edge that leaves each bit
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = w_tx_tick ? '0 : r_tx_cnt + c_CNT_ONE;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_tx_line_nxt  = r_tx_line;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt  = '0;
                w_tx_bit_nxt  = '0;
                w_tx_line_nxt = 1'b1;
                if (tx_valid) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_shift_nxt = w_tx_payload;
                    w_tx_par_nxt   = c_PAR_ODD ? ~^w_tx_payload : ^w_tx_payload;
                    w_tx_line_nxt  = 1'b0;
                end
            end
            TX_START: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_line_nxt  = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_tick) begin
                    if (r_tx_bit == c_DATA_LAST) begin
                        w_tx_bit_nxt = '0;
                        if (c_PAR_EN) begin
                            w_tx_state_nxt = TX_PARITY;
                            w_tx_line_nxt  = r_tx_par;
                        end else begin
                            w_tx_state_nxt = TX_STOP;
                            w_tx_line_nxt  = 1'b1;
                        end
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = r_tx_shift >> 1;
                        w_tx_line_nxt  = r_tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = TX_STOP;
                    w_tx_line_nxt  = 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_tick) begin
                    if (r_tx_bit == c_STOP_LAST) begin
                        w_tx_state_nxt = TX_IDLE;
                        w_tx_bit_nxt   = '0;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_line_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx_line  <= w_tx_line_nxt;
        end
    end

    assign tx       = r_tx_line;
    assign tx_ready = (r_tx_state == TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t              r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0]     r_rx_cnt,   w_rx_cnt_nxt;
    logic [2:0]             r_rx_bit,   w_rx_bit_nxt;
    logic [DATA_BITS-1:0]   r_rx_shift, w_rx_shift_nxt;
    logic                   r_rx_acc,   w_rx_acc_nxt;
    logic                   r_rx_perr,  w_rx_perr_nxt;
    logic [7:0]             r_rx_data,  w_rx_data_nxt;
    logic                   r_rx_valid, w_rx_valid_nxt;
    logic                   r_rx_ferr,  w_rx_ferr_nxt;
    logic                   r_rx_pout,  w_rx_pout_nxt;
    logic                   w_rx_tick;

    assign w_rx_tick = (r_rx_cnt == c_DIV_MAX);

    // The START half-bit wait centres every later sample in its bit cell.
    // Outputs are loaded on the stop-sample edge, giving the one-cycle lag.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = w_rx_tick ? '0 : r_rx_cnt + c_CNT_ONE;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_acc_nxt   = r_rx_acc;
        w_rx_perr_nxt  = r_rx_perr;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_rx_ferr_nxt  = r_rx_ferr;
        w_rx_pout_nxt  = r_rx_pout;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt  = '0;
                w_rx_bit_nxt  = '0;
                w_rx_acc_nxt  = 1'b0;
                w_rx_perr_nxt = 1'b0;
                if (!r_rx_s) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_HALF_MAX) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = r_rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_CNT_ONE;
                end
            end
            RX_DATA: begin
                if (w_rx_tick) begin
                    w_rx_shift_nxt = {r_rx_s, r_rx_shift[DATA_BITS-1:1]};
                    w_rx_acc_nxt   = r_rx_acc ^ r_rx_s;
                    if (r_rx_bit == c_DATA_LAST) begin
                        w_rx_bit_nxt   = '0;
                        w_rx_state_nxt = c_PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (w_rx_tick) begin
                    w_rx_perr_nxt  = ((r_rx_acc ^ r_rx_s) != c_PAR_ODD);
                    w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_valid_nxt = 1'b1;
                    w_rx_data_nxt  = 8'(r_rx_shift);
                    w_rx_ferr_nxt  = ~r_rx_s;
                    w_rx_pout_nxt  = r_rx_perr;
                    // A low stop bit means a held-low line: wait for release
                    w_rx_state_nxt = r_rx_s ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                w_rx_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_acc   <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_pout  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_acc   <= w_rx_acc_nxt;
            r_rx_perr  <= w_rx_perr_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_ferr  <= w_rx_ferr_nxt;
            r_rx_pout  <= w_rx_pout_nxt;
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_frame_err  = r_rx_ferr;
    assign rx_parity_err = r_rx_pout;
    assign busy_flag     = (r_tx_state != TX_IDLE) || (r_rx_state != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_param_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_param_core
//  Description : Scoreboard bench for uart_param_core. Three instances:
//                A = 8N1 loopback (BAUD_DIV 16) with an rx override,
//                B = 7E2 loopback (BAUD_DIV 10), C = 8O1 with bench-driven rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_param_core;

    localparam int A_DIV = 16;
    localparam int B_DIV = 10;
    localparam int C_DIV = 12;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   nv_a = 0;

    // DUT A
    logic       a_ovr = 1'b0, a_drv = 1'b1, txv_a = 1'b0;
    logic [7:0] txd_a = '0;
    wire        tx_a, ready_a, valid_a, fe_a, pe_a, busy_a, rx_a;
    wire  [7:0] rxd_a;
    assign rx_a = a_ovr ? a_drv : tx_a;

    uart_param_core #(.CLK_FREQ(A_DIV * 1000), .BAUD(1000)) u_a (
        .sys_clk(clk), .rst_n(rst_n), .rx(rx_a), .tx(tx_a),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(ready_a),
        .rx_data(rxd_a), .rx_valid(valid_a), .rx_frame_err(fe_a),
        .rx_parity_err(pe_a), .busy_flag(busy_a));

    // DUT B
    logic       txv_b = 1'b0;
    logic [7:0] txd_b = '0;
    wire        tx_b, ready_b, valid_b, fe_b, pe_b, busy_b;
    wire  [7:0] rxd_b;

    uart_param_core #(.CLK_FREQ(B_DIV * 1000), .BAUD(1000), .DATA_BITS(7),
                      .PARITY(2), .STOP_BITS(2)) u_b (
        .sys_clk(clk), .rst_n(rst_n), .rx(tx_b), .tx(tx_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(ready_b),
        .rx_data(rxd_b), .rx_valid(valid_b), .rx_frame_err(fe_b),
        .rx_parity_err(pe_b), .busy_flag(busy_b));

    // DUT C
    logic       drv_c = 1'b1;
    wire        tx_c, ready_c, valid_c, fe_c, pe_c, busy_c;
    wire  [7:0] rxd_c;

    uart_param_core #(.CLK_FREQ(C_DIV * 1000), .BAUD(1000), .PARITY(1)) u_c (
        .sys_clk(clk), .rst_n(rst_n), .rx(drv_c), .tx(tx_c),
        .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(ready_c),
        .rx_data(rxd_c), .rx_valid(valid_c), .rx_frame_err(fe_c),
        .rx_parity_err(pe_c), .busy_flag(busy_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference models: a loopback frame returns the payload truncated to
    // the data width; a driven frame is judged by its bits directly.
    function automatic exp_t model_loop(input logic [7:0] d, input int db);
        exp_t e;
        e.d  = 8'(int'(d) % (1 << db));
        e.fe = 1'b0;
        e.pe = 1'b0;
        return e;
    endfunction

    // Odd parity: the frame is clean when data ones plus parity bit is odd.
    function automatic exp_t model_drv(input logic [7:0] d, input logic pb, input logic sb);
        exp_t e;
        e.d  = d;
        e.fe = (sb == 1'b0);
        e.pe = ((($countones(d) + int'(pb)) % 2) != 1);
        return e;
    endfunction

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid_a) begin
            nv_a++;
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_rx: got data %02h, required no frame", rxd_a);
            end else begin
                e = q_a.pop_front();
                check("a_rx_data", 32'(rxd_a), 32'(e.d));
                check("a_rx_flags", {30'd0, fe_a, pe_a}, {30'd0, e.fe, e.pe});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid_b) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_rx: got data %02h, required no frame", rxd_b);
            end else begin
                e = q_b.pop_front();
                check("b_rx_data", 32'(rxd_b), 32'(e.d));
                check("b_rx_flags", {30'd0, fe_b, pe_b}, {30'd0, e.fe, e.pe});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid_c) begin
            if (q_c.size() == 0) begin
                total++; bad++;
                $display("FAIL c_unexpected_rx: got data %02h, required no frame", rxd_c);
            end else begin
                e = q_c.pop_front();
                check("c_rx_data", 32'(rxd_c), 32'(e.d));
                check("c_rx_flags", {30'd0, fe_c, pe_c}, {30'd0, e.fe, e.pe});
            end
        end
    end

    // Every A frame must keep tx_ready low for exactly 10 bit times
    int lowcnt_a = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            lowcnt_a = 0;
        end else if (!ready_a) begin
            lowcnt_a++;
        end else if (lowcnt_a != 0) begin
            check("a_ready_low_cycles", 32'(lowcnt_a), 32'(10 * A_DIV));
            lowcnt_a = 0;
        end
    end

    task automatic send(input int which, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(which == 0 ? ready_a : ready_b) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            total++; bad++;
            $display("FAIL send_ready_timeout: dut %0d tx_ready=0, required 1", which);
            return;
        end
        if (which == 0) begin txv_a = 1'b1; txd_a = d; end
        else            begin txv_b = 1'b1; txd_b = d; end
        @(posedge clk);
        if (which == 0) q_a.push_back(model_loop(d, 8));
        else            q_b.push_back(model_loop(d, 7));
        @(negedge clk);
        txv_a = 1'b0;
        txv_b = 1'b0;
    endtask

    task automatic drive_c(input logic [7:0] d, input logic pb, input logic sb);
        logic [10:0] bits;
        bits = {sb, pb, d, 1'b0};
        q_c.push_back(model_drv(d, pb, sb));
        for (int i = 0; i < 11; i++) begin
            drv_c = bits[i];
            repeat (C_DIV) @(negedge clk);
        end
        drv_c = 1'b1;
        repeat (2 * C_DIV) @(negedge clk);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy_a || busy_b || busy_c || q_a.size() != 0 || q_b.size() != 0 ||
                q_c.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            total++; bad++;
            $display("FAIL %s_timeout: busy=%0d%0d%0d pending=%0d/%0d/%0d, required idle", name,
                     busy_a, busy_b, busy_c, q_a.size(), q_b.size(), q_c.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   base;
        logic [10:0] eb;
        logic [7:0]  d7;
        exp_t        ebrk;

        // ---------------- reset values ----------------
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset", {24'd0, tx_a, ready_a, valid_a, fe_a, pe_a, busy_a, 2'b00}, 32'hC0);
        check("a_reset_rx_data", 32'(rxd_a), 32'h0);
        check("b_reset", {16'd0, tx_b, ready_b, rxd_b, valid_b, fe_b, pe_b, busy_b, 2'b00}, 32'hC000);
        check("c_reset", {16'd0, tx_c, ready_c, rxd_c, valid_c, fe_c, pe_c, busy_c, 2'b00}, 32'hC000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- A: back-to-back loopback ----------------
        for (int j = 0; j < 8; j++) send(0, 8'(j * 10 + 3));
        for (int j = 0; j < 6; j++) send(0, 8'($urandom));
        wait_quiet("a_b2b");

        // ---------------- B: exact bit sequence for 0x55 ----------------
        d7 = 8'h55 % 8'd128;
        eb[0] = 1'b0;
        for (int i = 0; i < 7; i++) eb[i + 1] = d7[i];
        eb[8]  = 1'($countones(d7) % 2);
        eb[9]  = 1'b1;
        eb[10] = 1'b1;
        send(1, 8'h55);
        for (int i = 0; i < 11; i++) begin
            repeat ((i == 0) ? B_DIV / 2 : B_DIV) @(negedge clk);
            check($sformatf("b_tx_bit%0d", i), 32'(tx_b), 32'(eb[i]));
        end
        repeat (B_DIV / 2 - 1) @(negedge clk);
        check("b_ready_last_cycle", 32'(ready_b), 32'd0);
        @(negedge clk);
        check("b_ready_after_frame", 32'(ready_b), 32'd1);
        for (int j = 0; j < 4; j++) send(1, 8'($urandom));
        wait_quiet("b_loop");

        // ---------------- C: odd parity on driven frames ----------------
        drive_c(8'h01, 1'b0, 1'b1);
        drive_c(8'h01, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++)
            drive_c(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        wait_quiet("c_drv");

        // ---------------- A: glitch and break ----------------
        a_drv = 1'b1;
        a_ovr = 1'b1;
        @(negedge clk);
        base  = nv_a;
        a_drv = 1'b0;
        repeat (A_DIV / 2 - 2) @(negedge clk);
        a_drv = 1'b1;
        repeat (3 * A_DIV) @(negedge clk);
        check("a_glitch_no_valid", 32'(nv_a), 32'(base));
        check("a_glitch_idle", 32'(busy_a), 32'd0);
        ebrk.d = 8'h00; ebrk.fe = 1'b1; ebrk.pe = 1'b0;
        q_a.push_back(ebrk);
        a_drv = 1'b0;
        repeat (3 * 10 * A_DIV) @(negedge clk);
        check("a_break_one_valid", 32'(nv_a), 32'(base + 1));
        check("a_break_held", 32'(busy_a), 32'd1);
        a_drv = 1'b1;
        repeat (A_DIV) @(negedge clk);
        check("a_break_released", 32'(busy_a), 32'd0);
        check("a_break_still_one", 32'(nv_a), 32'(base + 1));
        a_ovr = 1'b0;
        send(0, 8'($urandom));
        wait_quiet("a_break");

        // ---------------- A: reset mid-frame ----------------
        send(0, 8'h3C);
        repeat (4 * A_DIV + A_DIV / 2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("a_rst_tx", 32'(tx_a), 32'd1);
        check("a_rst_ready", 32'(ready_a), 32'd1);
        check("a_rst_busy", 32'(busy_a), 32'd0);
        q_a.delete();
        base = nv_a;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'hA5);
        wait_quiet("a_rst");
        check("a_rst_frames_after", 32'(nv_a), 32'(base + 1));

        // ---------------- A: handshake with data changing every cycle ----------------
        // tx_ready is low for 10 bit times then high for one cycle, so with
        // tx_valid held high the accepted bytes are one frame period apart.
        begin
            int period;
            logic [7:0] d;
            period = 10 * A_DIV + 1;
            for (int c = 0; c < 3 * period; c++) begin
                d = 8'($urandom);
                txv_a = 1'b1;
                txd_a = d;
                if (c % period == 0) q_a.push_back(model_loop(d, 8));
                @(negedge clk);
            end
            txv_a = 1'b0;
        end
        wait_quiet("a_hs");

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("c_queue_drained", 32'(q_c.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
